dmem_rmw_ctrl: RTL and testbench

//  Multi-cycle sequencer between the MIPS core's load/store port and a word-wide data memory with a ready handshake.

---
 rtl/mem_ctrl_pkg.sv | 28 ++
 rtl/store_merge.sv | 25 ++
 rtl/dmem_rmw_ctrl.sv | 163 ++++++++++++++++
 tb/tb_dmem_rmw_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared store-size codes, controller state encoding and alignment helper for dmem_rmw_ctrl.
package mem_ctrl_pkg;

    localparam logic [1:0] MW_NONE = 2'b00;
    localparam logic [1:0] MW_BYTE = 2'b01;
    localparam logic [1:0] MW_HALF = 2'b10;
    localparam logic [1:0] MW_WORD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        LD,
        DONE
    } state_t;

    // Half must be 2-byte aligned; word stores and loads must be 4-byte aligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic rd,
                                           input logic [1:0] addr_lo);
        case (size)
            MW_HALF: return addr_lo[0];
            MW_WORD: return addr_lo != 2'b00;
            MW_NONE: return rd && (addr_lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_merge.sv
// Merges sub-word store data into the old memory word (little-endian lanes).
module store_merge
    import mem_ctrl_pkg::*;
(
    input  logic [31:0] i_old_word,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    output logic [31:0] o_merged
);

    always_comb begin
        o_merged = i_old_word;
        case (i_size)
            MW_BYTE: o_merged[{i_addr_lo, 3'b000} +: 8] = i_wdata[7:0];
            MW_HALF: begin
                if (i_addr_lo[1]) o_merged[31:16] = i_wdata[15:0];
                else              o_merged[15:0]  = i_wdata[15:0];
            end
            MW_WORD: o_merged = i_wdata;
            default: o_merged = i_old_word;
        endcase
    end

endmodule

// File: rtl/dmem_rmw_ctrl.sv
// Load/store sequencer for a ready-handshaked word memory; sub-word stores via read-modify-write.
// Optional misalignment trapping is enabled by defining DMEM_ALIGN_CHECK_EN.
module dmem_rmw_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int unsigned MEM_AW   = 6,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        cpu_memwrite,
    input  logic              cpu_memread,
    input  logic [31:0]       cpu_addr,
    input  logic [31:0]       cpu_wdata,
    output logic [31:0]       cpu_rdata,
    output logic              cpu_stall,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              bus_err,
    output logic              align_err
);

    localparam int unsigned CW = $clog2(WAIT_MAX + 1);

    state_t            r_state;
    logic [1:0]        r_size;
    logic [1:0]        r_addr_lo;
    logic [31:0]       r_wdata;
    logic [CW-1:0]     r_wait_cnt;
    logic [MEM_AW-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic [31:0]       r_cpu_rdata;
    logic              r_mem_we;
    logic              r_mem_re;
    logic              r_bus_err;
    logic              r_align_err;

    logic              w_req;
    logic              w_misaligned;
    logic              w_timeout;
    logic [31:0]       w_merged;
    logic              w_unused;

    assign w_req     = (cpu_memwrite != MW_NONE) || cpu_memread;
    assign w_timeout = (r_wait_cnt == CW'(WAIT_MAX - 1));
    assign w_unused  = ^cpu_addr[31:MEM_AW+2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(cpu_memwrite, cpu_memread, cpu_addr[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    store_merge u_store_merge (
        .i_old_word (mem_rdata),
        .i_wdata    (r_wdata),
        .i_addr_lo  (r_addr_lo),
        .i_size     (r_size),
        .o_merged   (w_merged)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_size      <= MW_NONE;
            r_addr_lo   <= 2'b00;
            r_wdata     <= 32'h0;
            r_wait_cnt  <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'h0;
            r_cpu_rdata <= 32'h0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
            r_bus_err   <= 1'b0;
            r_align_err <= 1'b0;
        end else begin
            r_bus_err   <= 1'b0;
            r_align_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_mem_addr <= cpu_addr[MEM_AW+1:2];
                        r_addr_lo  <= cpu_addr[1:0];
                        r_size     <= cpu_memwrite;
                        r_wdata    <= cpu_wdata;
                        r_wait_cnt <= '0;
                        if (w_misaligned) begin
                            r_align_err <= 1'b1;
                            r_state     <= DONE;
                        end else if (cpu_memwrite == MW_WORD) begin
                            r_mem_wdata <= cpu_wdata;
                            r_mem_we    <= 1'b1;
                            r_state     <= WR;
                        end else if (cpu_memwrite != MW_NONE) begin
                            r_mem_re <= 1'b1;
                            r_state  <= RD;
                        end else begin
                            r_mem_re <= 1'b1;
                            r_state  <= LD;
                        end
                    end
                end
                RD: begin
                    if (mem_ready) begin
                        r_mem_wdata <= w_merged;
                        r_mem_re    <= 1'b0;
                        r_mem_we    <= 1'b1;
                        r_wait_cnt  <= '0;
                        r_state     <= WR;
                    end else if (w_timeout) begin
                        r_mem_re  <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                WR: begin
                    if (mem_ready) begin
                        r_mem_we <= 1'b0;
                        r_state  <= DONE;
                    end else if (w_timeout) begin
                        r_mem_we  <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                LD: begin
                    if (mem_ready) begin
                        r_cpu_rdata <= mem_rdata;
                        r_mem_re    <= 1'b0;
                        r_state     <= DONE;
                    end else if (w_timeout) begin
                        r_mem_re  <= 1'b0;
                        r_bus_err <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + CW'(1);
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // Stall is combinational so a new request freezes the core in the same cycle.
    assign cpu_stall = (r_state == IDLE) ? w_req : (r_state != DONE);
    assign cpu_rdata = r_cpu_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_re    = r_mem_re;
    assign bus_err   = r_bus_err;
    assign align_err = r_align_err;

endmodule

// File: tb/tb_dmem_rmw_ctrl.sv
// Self-checking bench for dmem_rmw_ctrl: memory responder, transaction-level model, per-cycle checker.
module tb_dmem_rmw_ctrl;
    import mem_ctrl_pkg::*;

    localparam int WAIT_MAX = 15;

    logic        clk;
    logic        reset;
    logic [1:0]  cpu_memwrite;
    logic        cpu_memread;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        bus_err;
    logic        align_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] tb_mem  [64];
    logic [31:0] ref_mem [64];
    int          n_wr = 0;
    int          n_rd = 0;
    int          age  = 0;
    int          ready_delay = 0;
    logic        ready_never = 1'b0;
    logic        force_ready = 1'b0;
    logic        mem_init    = 1'b1;
    logic        poke_en     = 1'b0;
    logic [5:0]  poke_addr   = '0;
    logic [31:0] poke_data   = '0;

    logic        exp_read_ok  = 1'b0;
    logic        exp_write_ok = 1'b0;
    logic [5:0]  exp_addr     = '0;
    logic [31:0] exp_merged   = '0;
    logic [31:0] exp_rdata    = '0;

    dmem_rmw_ctrl #(.MEM_AW(6), .WAIT_MAX(WAIT_MAX)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_memwrite (cpu_memwrite),
        .cpu_memread  (cpu_memread),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_rdata    (cpu_rdata),
        .cpu_stall    (cpu_stall),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_re       (mem_re),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .bus_err      (bus_err),
        .align_err    (align_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference merge written with masks and shifts.
    function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] a, input logic [1:0] size);
        int sh;
        logic [31:0] mask;
        if (size == MW_WORD) return wd;
        if (size == MW_BYTE) begin
            sh   = 8 * int'(a);
            mask = 32'hFF << sh;
        end else if (size == MW_HALF) begin
            sh   = a[1] ? 16 : 0;
            mask = 32'hFFFF << sh;
        end else begin
            return old;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    function automatic logic model_misal(input logic [1:0] size, input logic [1:0] a);
        return ((size == MW_HALF) && a[0]) || (((size == MW_WORD) || (size == MW_NONE)) && (a != 2'b00));
    endfunction

    // Memory responder: ready after ready_delay wait cycles of a held strobe.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) tb_mem[i] <= 32'(i) * 32'h01010101;
        end else if (poke_en) begin
            tb_mem[poke_addr] <= poke_data;
        end else if (mem_we && mem_ready) begin
            tb_mem[mem_addr] <= mem_wdata;
        end
        if (mem_we && mem_ready) n_wr <= n_wr + 1;
        if (mem_re && mem_ready) n_rd <= n_rd + 1;
        if ((mem_we || mem_re) && !mem_ready) age <= age + 1;
        else                                  age <= 0;
    end

    always @(negedge clk) begin
        mem_ready = force_ready || ((mem_we || mem_re) && !ready_never && (age >= ready_delay));
        mem_rdata = tb_mem[mem_addr];
    end

    // Per-cycle checker against the current expected transaction.
    always @(negedge clk) begin
        if (!exp_write_ok) check("spurious_we", 32'(mem_we), 32'h0);
        if (!exp_read_ok)  check("spurious_re", 32'(mem_re), 32'h0);
        if (mem_we || mem_re) check("mem_addr", 32'(mem_addr), 32'(exp_addr));
        if (mem_we && exp_write_ok) check("mem_wdata", mem_wdata, exp_merged);
    end

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        poke_addr  = a;
        poke_data  = d;
        poke_en    = 1'b1;
        ref_mem[a] = d;
        @(posedge clk);
        #1;
        poke_en = 1'b0;
    endtask

    task automatic run_txn(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wd,
                           input int delay, input logic never, output int lat);
        logic [5:0] idx;
        logic       is_load, misal, abort, done;
        int         n_acc, exp_lat, exp_rd, exp_wr, wr0, rd0;
        idx     = addr[7:2];
        is_load = (size == MW_NONE);
        misal   = 1'b0;
`ifdef DMEM_ALIGN_CHECK_EN
        misal   = model_misal(size, addr[1:0]);
`endif
        abort   = !misal && (never || (delay >= WAIT_MAX));
        n_acc   = ((size == MW_BYTE) || (size == MW_HALF)) ? 2 : 1;
        exp_lat = misal ? 2 : (abort ? 2 + WAIT_MAX : 2 + n_acc * (delay + 1));
        exp_rd  = (misal || abort || (size == MW_WORD)) ? 0 : 1;
        exp_wr  = (misal || abort || is_load) ? 0 : 1;
        exp_addr     = idx;
        exp_merged   = merge_model(ref_mem[idx], wd, addr[1:0], size);
        exp_read_ok  = !misal && (size != MW_WORD);
        exp_write_ok = !misal && !is_load;
        ready_delay  = delay;
        ready_never  = never;
        wr0 = n_wr;
        rd0 = n_rd;

        @(posedge clk);
        #1;
        cpu_memwrite = size;
        cpu_memread  = is_load;
        cpu_addr     = addr;
        cpu_wdata    = wd;
        @(negedge clk);
        check("stall_on_req", 32'(cpu_stall), 32'h1);
        lat = 1;
        @(posedge clk);
        #1;
        cpu_memwrite = MW_NONE;
        cpu_memread  = 1'b0;
        cpu_addr     = addr ^ 32'h3C;
        cpu_wdata    = ~wd;
        done = 1'b0;
        while (!done && (lat < 64)) begin
            @(negedge clk);
            lat++;
            if (!cpu_stall) done = 1'b1;
        end
        check("done_reached", 32'(done), 32'h1);
        check("latency", 32'(lat), 32'(exp_lat));
        check("bus_err", 32'(bus_err), 32'(abort));
        check("align_err", 32'(align_err), 32'(misal));
        if (is_load && !misal && !abort) exp_rdata = ref_mem[idx];
        check("cpu_rdata", cpu_rdata, exp_rdata);
        exp_read_ok  = 1'b0;
        exp_write_ok = 1'b0;
        if (exp_wr != 0) ref_mem[idx] = exp_merged;
        @(negedge clk);
        check("pulses_cleared", 32'({bus_err, align_err}), 32'h0);
        check("stall_idle", 32'(cpu_stall), 32'h0);
        check("write_count", 32'(n_wr - wr0), 32'(exp_wr));
        check("read_count", 32'(n_rd - rd0), 32'(exp_rd));
        check("mem_word", tb_mem[idx], ref_mem[idx]);
        ready_never = 1'b0;
        ready_delay = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, wr0, rd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'(i) * 32'h01010101;
        reset        = 1'b0;
        cpu_memwrite = MW_NONE;
        cpu_memread  = 1'b0;
        cpu_addr     = 32'h0;
        cpu_wdata    = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        check("rst_outputs", {mem_we, mem_re, bus_err, align_err, cpu_stall}, 32'h0);
        check("rst_rdata", cpu_rdata, 32'h0);
        check("rst_wdata", mem_wdata, 32'h0);
        check("rst_addr", 32'(mem_addr), 32'h0);
        reset = 1'b1;

        // Ready while no strobe is up must not start anything.
        wr0 = n_wr;
        rd0 = n_rd;
        force_ready = 1'b1;
        repeat (3) @(negedge clk);
        force_ready = 1'b0;
        @(negedge clk);
        check("idle_ready_acc", 32'((n_wr - wr0) + (n_rd - rd0)), 32'h0);
        check("idle_ready_stall", 32'(cpu_stall), 32'h0);

        poke(6'd20, 32'hAAAA5555);
        run_txn(MW_HALF, 32'd80, 32'h0000FFFF, 0, 1'b0, lat);
        check("sh_lat_lit", 32'(lat), 32'd4);
        check("sh_mem_lit", tb_mem[20], 32'hAAAAFFFF);

        poke(6'd20, 32'h0);
        run_txn(MW_BYTE, 32'h53, 32'h00000012, 0, 1'b0, lat);
        check("sb_mem_lit", tb_mem[20], 32'h12000000);

        run_txn(MW_WORD, 32'd84, 32'hDEADBEEF, 3, 1'b0, lat);
        check("sw_wait_lat_lit", 32'(lat), 32'd6);

        run_txn(MW_HALF, 32'd86, 32'hAB123456, 1, 1'b0, lat);
        run_txn(MW_NONE, 32'd84, 32'h0, 2, 1'b0, lat);
        check("lw_rdata_lit", cpu_rdata, 32'h3456BEEF);

        run_txn(MW_BYTE, 32'h41, 32'h000000AB, 0, 1'b0, lat);
        check("sb_lane1_lit", tb_mem[16], 32'h1010AB10);

        run_txn(MW_NONE, 32'd80, 32'h0, 0, 1'b1, lat);
        check("lw_timeout_lat_lit", 32'(lat), 32'd17);
        run_txn(MW_BYTE, 32'h44, 32'h000000EE, 0, 1'b1, lat);
        run_txn(MW_WORD, 32'd88, 32'h0BADF00D, 14, 1'b0, lat);
        check("sw_last_ready_lit", tb_mem[22], 32'h0BADF00D);
        run_txn(MW_WORD, 32'd92, 32'h12345678, 15, 1'b0, lat);
        check("sw_timeout_mem_lit", tb_mem[23], 32'h17171717);

        // Reset asserted while the RMW read is in flight.
        poke(6'd20, 32'h11223344);
        wr0          = n_wr;
        exp_addr     = 6'd20;
        exp_read_ok  = 1'b1;
        exp_write_ok = 1'b0;
        @(posedge clk);
        #1;
        cpu_memwrite = MW_HALF;
        cpu_addr     = 32'd82;
        cpu_wdata    = 32'h0000BEEF;
        @(negedge clk);
        check("rst_mid_stall", 32'(cpu_stall), 32'h1);
        @(posedge clk);
        #1;
        cpu_memwrite = MW_NONE;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_in_rd", 32'(mem_re), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        exp_read_ok = 1'b0;
        exp_rdata   = 32'h0;
        @(negedge clk);
        check("rst_mid_strobes", 32'({mem_we, mem_re, cpu_stall}), 32'h0);
        check("rst_mid_rdata", cpu_rdata, 32'h0);
        repeat (4) @(negedge clk);
        check("rst_mid_no_write", 32'(n_wr - wr0), 32'h0);
        check("rst_mid_mem", tb_mem[20], 32'h11223344);

        run_txn(MW_WORD, 32'd81, 32'hCAFEF00D, 0, 1'b0, lat);
`ifdef DMEM_ALIGN_CHECK_EN
        check("misal_sw_lat_lit", 32'(lat), 32'd2);
        check("misal_sw_mem_lit", tb_mem[20], 32'h11223344);
`else
        check("unal_sw_mem_lit", tb_mem[20], 32'hCAFEF00D);
`endif
        run_txn(MW_HALF, 32'd83, 32'h00007777, 0, 1'b0, lat);
        run_txn(MW_NONE, 32'd82, 32'h0, 0, 1'b0, lat);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
